// File: rtl/cpu_run_controller.sv
// ---------------------------------------------------------------------------
// CpuRunController (module cpu_run_controller)
//
// Purpose:
//   Sequences one bounded run of a CPU and then dumps its architectural
//   state. After a start request the CPU is clock-enabled for at most
//   CYCLES cycles, or fewer if the CPU side raises halt_req. The controller
//   then streams every register-file entry, followed by every data-memory
//   word, over a valid/ready channel. DONE is terminal until the next reset.
//
// Parameters:
//   CYCLES     maximum clock-enabled CPU cycles per run (0 skips the run)
//   NREGS      register-file entries dumped (at least 2)
//   MEM_WORDS  data-memory words dumped (at least 1)
//   DATA_W     data width of the register and memory read ports
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        begin a run, honoured in IDLE only
//   halt_req     early stop request from the CPU, honoured in RUN only
//   cpu_en       write/advance enable for the CPU, high only in RUN
//   dbg_reg_a    register-file debug read index
//   dbg_reg_rd   combinational register-file read data
//   dbg_mem_a    data-memory debug byte address (word index * 4)
//   dbg_mem_rd   combinational data-memory read data
//   dump_valid   dump beat valid, high throughout both dump phases
//   dump_ready   consumer accepts the current beat
//   dump_kind    0 = register beat, 1 = memory beat
//   dump_index   register index or memory byte address of the beat
//   dump_data    dumped value
//   busy         high in RUN, DUMP_REG and DUMP_MEM
//   done         high in DONE
//   cycle_count  enabled CPU cycles completed in the current run
// ---------------------------------------------------------------------------
module cpu_run_controller #(
    parameter int CYCLES    = 10000,
    parameter int NREGS     = 32,
    parameter int MEM_WORDS = 64,
    parameter int DATA_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      start,
    input  logic                      halt_req,
    output logic                      cpu_en,

    output logic [$clog2(NREGS)-1:0]  dbg_reg_a,
    input  logic [DATA_W-1:0]         dbg_reg_rd,
    output logic [31:0]               dbg_mem_a,
    input  logic [DATA_W-1:0]         dbg_mem_rd,

    output logic                      dump_valid,
    input  logic                      dump_ready,
    output logic                      dump_kind,
    output logic [31:0]               dump_index,
    output logic [DATA_W-1:0]         dump_data,

    output logic                      busy,
    output logic                      done,
    output logic [31:0]               cycle_count
);

    // Width of the register index; the memory word index is sized so a
    // single-word memory still gets a legal one-bit counter.
    localparam int RA_W = $clog2(NREGS);
    localparam int MA_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // Terminal counter values. RUN_LAST is meaningless when CYCLES is zero,
    // but the RUN state is never entered in that configuration.
    localparam logic [RA_W-1:0] REG_LAST  = RA_W'(NREGS - 1);
    localparam logic [MA_W-1:0] MEM_LAST  = MA_W'(MEM_WORDS - 1);
    localparam logic [31:0]     RUN_LAST  = 32'(CYCLES - 1);
    localparam bit              SKIP_RUN  = (CYCLES == 0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        DUMP_REG = 3'd2,
        DUMP_MEM = 3'd3,
        DONE     = 3'd4
    } state_e;

    state_e            state_q,   state_d;
    logic [31:0]       cycle_q,   cycle_d;
    logic [RA_W-1:0]   reg_idx_q, reg_idx_d;
    logic [MA_W-1:0]   mem_idx_q, mem_idx_d;

    // Byte address of the current memory word, shared by the debug port
    // and the dump index so both always agree.
    logic [31:0]       mem_addr;

    assign mem_addr    = 32'(mem_idx_q) << 2;
    assign cycle_count = cycle_q;

    // State register. Reset is asynchronous so that pulling rst_n low in the
    // middle of a run or dump immediately parks everything back in IDLE with
    // all counters cleared; every output below is decoded from these
    // registers, so they follow without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cycle_q   <= '0;
            reg_idx_q <= '0;
            mem_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            reg_idx_q <= reg_idx_d;
            mem_idx_q <= mem_idx_d;
        end
    end

    // Next-state logic. The run ends on the edge that completes the last
    // permitted cycle or on the first halt request; that edge still counts,
    // so cycle_count ends equal to the cycles actually executed. Dump
    // counters advance only on an accepted beat and return to zero on the
    // acceptance of their last beat, which is also what moves the phase on,
    // so they never wrap and never skip or repeat a beat.
    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        reg_idx_d = reg_idx_q;
        mem_idx_d = mem_idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cycle_d = '0;
                    state_d = SKIP_RUN ? DUMP_REG : RUN;
                end
            end

            RUN: begin
                cycle_d = cycle_q + 32'd1;
                if ((cycle_q == RUN_LAST) || halt_req) begin
                    state_d = DUMP_REG;
                end
            end

            DUMP_REG: begin
                if (dump_ready) begin
                    if (reg_idx_q == REG_LAST) begin
                        reg_idx_d = '0;
                        state_d   = DUMP_MEM;
                    end else begin
                        reg_idx_d = reg_idx_q + RA_W'(1);
                    end
                end
            end

            DUMP_MEM: begin
                if (dump_ready) begin
                    if (mem_idx_q == MEM_LAST) begin
                        mem_idx_d = '0;
                        state_d   = DONE;
                    end else begin
                        mem_idx_d = mem_idx_q + MA_W'(1);
                    end
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. Everything is a pure function of the registered state
    // and the combinational read data, so beat fields cannot change while
    // the consumer stalls: the index registers only move on acceptance.
    // The debug addresses are driven from the index registers in every
    // state; those registers are zero outside the dump phases.
    always_comb begin
        cpu_en     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        dump_valid = 1'b0;
        dump_kind  = 1'b0;
        dump_index = '0;
        dump_data  = '0;
        dbg_reg_a  = reg_idx_q;
        dbg_mem_a  = mem_addr;

        case (state_q)
            RUN: begin
                cpu_en = 1'b1;
                busy   = 1'b1;
            end

            DUMP_REG: begin
                busy       = 1'b1;
                dump_valid = 1'b1;
                dump_kind  = 1'b0;
                dump_index = 32'(reg_idx_q);
                dump_data  = dbg_reg_rd;
            end

            DUMP_MEM: begin
                busy       = 1'b1;
                dump_valid = 1'b1;
                dump_kind  = 1'b1;
                dump_index = mem_addr;
                dump_data  = dbg_mem_rd;
            end

            DONE: begin
                done = 1'b1;
            end

            default: begin
                cpu_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// ---------------------------------------------------------------------------
// Testbench for cpu_run_controller.
//
// The main instance uses a short run (CYC cycles) and small dump sizes so
// many randomized runs fit in a short simulation. A second instance with
// CYCLES=0 covers the skip-the-run configuration. Expected dump beats are
// queued when a run is launched; a monitor pops and compares them whenever
// a beat is transferred.
// ---------------------------------------------------------------------------
module tb_cpu_run_controller;

    localparam int CYC = 12;
    localparam int NR  = 4;
    localparam int MW  = 8;
    localparam int DW  = 32;

    typedef struct {
        logic          kind;
        logic [31:0]   index;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          dump_ready = 1'b0;
    logic          cpu_en;
    logic [1:0]    dbg_reg_a;
    logic [DW-1:0] dbg_reg_rd;
    logic [31:0]   dbg_mem_a;
    logic [DW-1:0] dbg_mem_rd;
    logic          dump_valid;
    logic          dump_kind;
    logic [31:0]   dump_index;
    logic [DW-1:0] dump_data;
    logic          busy;
    logic          done;
    logic [31:0]   cycle_count;

    // Signals of the CYCLES=0 instance
    logic          zStart = 1'b0;
    logic          zCpuEn;
    logic [0:0]    zRegA;
    logic [DW-1:0] zRegRd;
    logic [31:0]   zMemA;
    logic [DW-1:0] zMemRd;
    logic          zValid;
    logic          zKind;
    logic [31:0]   zIndex;
    logic [DW-1:0] zData;
    logic          zBusy;
    logic          zDone;
    logic [31:0]   zCount;

    logic [DW-1:0] regFile [NR];
    logic [DW-1:0] memFile [MW];

    beat_t expQ[$];

    int checks = 0;
    int fails  = 0;
    int enCount = 0;
    int dumpCycles = 0;
    int readyMode = 1;
    int readyPhase = 0;

    logic          stalled = 1'b0;
    logic          prevEn = 1'b0;
    logic          prevValid = 1'b0;
    logic          heldKind;
    logic [31:0]   heldIndex;
    logic [DW-1:0] heldData;

    // The CPU-side memories are modelled as arrays read combinationally.
    assign dbg_reg_rd = regFile[dbg_reg_a];
    assign dbg_mem_rd = memFile[dbg_mem_a[4:2]];
    assign zRegRd     = 32'hA000_0000 | 32'(zRegA);
    assign zMemRd     = 32'hB000_0000 | zMemA;

    cpu_run_controller #(
        .CYCLES(CYC), .NREGS(NR), .MEM_WORDS(MW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start(start), .halt_req(halt_req), .cpu_en(cpu_en),
        .dbg_reg_a(dbg_reg_a), .dbg_reg_rd(dbg_reg_rd),
        .dbg_mem_a(dbg_mem_a), .dbg_mem_rd(dbg_mem_rd),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_kind(dump_kind), .dump_index(dump_index), .dump_data(dump_data),
        .busy(busy), .done(done), .cycle_count(cycle_count)
    );

    cpu_run_controller #(
        .CYCLES(0), .NREGS(2), .MEM_WORDS(2), .DATA_W(DW)
    ) dutZero (
        .clk(clk), .rst_n(rst_n),
        .start(zStart), .halt_req(1'b0), .cpu_en(zCpuEn),
        .dbg_reg_a(zRegA), .dbg_reg_rd(zRegRd),
        .dbg_mem_a(zMemA), .dbg_mem_rd(zMemRd),
        .dump_valid(zValid), .dump_ready(1'b1),
        .dump_kind(zKind), .dump_index(zIndex), .dump_data(zData),
        .busy(zBusy), .done(zDone), .cycle_count(zCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Consumer back-pressure: 0 = random, 1 = always ready, 2 = 1,0,0 pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: dump_ready = 1'($urandom_range(0, 1));
                1: dump_ready = 1'b1;
                default: begin
                    dump_ready = (readyPhase % 3 == 0);
                    readyPhase++;
                end
            endcase
        end
    end

    // Monitor: samples on the falling edge, pops one expected beat per
    // transfer, checks stalled beats hold still, and counts enabled cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled   = 1'b0;
            prevEn    = 1'b0;
            prevValid = 1'b0;
        end else begin
            if (cpu_en) enCount++;
            if (dump_valid) dumpCycles++;
            if (dump_valid && !prevValid)
                checkOutput("dumpFollowsRun", prevEn, 1'b1);
            if (dump_valid && stalled) begin
                checkOutput("stallKind", dump_kind, heldKind);
                checkOutput("stallIndex", dump_index, heldIndex);
                checkOutput("stallData", dump_data, heldData);
            end
            if (dump_valid && dump_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", dump_index, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    beat_t e;
                    e = expQ.pop_front();
                    checkOutput("beatKind", dump_kind, e.kind);
                    checkOutput("beatIndex", dump_index, e.index);
                    checkOutput("beatData", dump_data, e.data);
                end
                stalled = 1'b0;
            end else if (dump_valid) begin
                stalled   = 1'b1;
                heldKind  = dump_kind;
                heldIndex = dump_index;
                heldData  = dump_data;
            end else begin
                stalled = 1'b0;
            end
            prevEn    = cpu_en;
            prevValid = dump_valid;
        end
    end

    task automatic resetDut();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Launches a run: fresh memory contents, expected beats queued, halt
    // pulsed on RUN cycle haltAt (0 = never). Returns cycles the run should
    // execute. Halt and start are randomized once the run should be over.
    task automatic applyStimulus(input int haltAt, input int mode, output int expCycles);
        expCycles = (haltAt >= 1 && haltAt <= CYC) ? haltAt : CYC;
        readyMode  = mode;
        readyPhase = 0;
        for (int i = 0; i < NR; i++) regFile[i] = $urandom;
        for (int i = 0; i < MW; i++) memFile[i] = $urandom;
        for (int i = 0; i < NR; i++) expQ.push_back('{1'b0, 32'(i), regFile[i]});
        for (int i = 0; i < MW; i++) expQ.push_back('{1'b1, 32'(i * 4), memFile[i]});

        // Halt requests in IDLE are ignored.
        repeat (2) begin
            halt_req = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checkOutput("idleNotBusy", {busy, cpu_en}, 2'b00);
        end
        halt_req   = 1'b0;
        enCount    = 0;
        dumpCycles = 0;
        start      = 1'b1;
        for (int k = 1; k <= CYC + 2; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k == 1) begin
                checkOutput("runStartCount", cycle_count, 0);
                checkOutput("runStartEn", cpu_en, 1'b1);
            end
            if (k > expCycles) begin
                halt_req = 1'($urandom_range(0, 1));
                start    = 1'($urandom_range(0, 1));
            end else begin
                halt_req = (k == haltAt);
            end
        end
    endtask

    task automatic finishRun(input int expCycles, input int mode);
        bit reached;
        reached = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                reached = 1;
                break;
            end
            start    = 1'($urandom_range(0, 1));
            halt_req = 1'($urandom_range(0, 1));
        end
        start    = 1'b0;
        halt_req = 1'b0;
        checkOutput("doneReached", reached, 1'b1);
        checkOutput("finalCount", cycle_count, expCycles);
        checkOutput("enabledCycles", enCount, expCycles);
        checkOutput("beatsLeft", expQ.size(), 0);
        checkOutput("doneOutputs", {busy, cpu_en, dump_valid}, 3'b000);
        if (mode == 1) checkOutput("dumpCycles", dumpCycles, NR + MW);

        // Start held high in DONE is ignored.
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("doneSticky", {done, busy, cpu_en, dump_valid}, 4'b1000);
        checkOutput("doneCountHeld", cycle_count, expCycles);
        start = 1'b0;
    endtask

    // CYCLES=0: the dump begins the cycle after start, cpu_en never rises.
    task automatic zeroTest();
        bit enSeen;
        enSeen = 0;
        @(posedge clk);
        #1;
        zStart = 1'b1;
        @(posedge clk);
        #1;
        zStart = 1'b0;
        @(negedge clk);
        checkOutput("zeroFirstValid", zValid, 1'b1);
        checkOutput("zeroFirstKind", zKind, 1'b0);
        checkOutput("zeroFirstIndex", zIndex, 0);
        checkOutput("zeroFirstData", zData, 32'hA000_0000);
        for (int i = 0; i < 10; i++) begin
            if (zCpuEn) enSeen = 1;
            @(negedge clk);
        end
        checkOutput("zeroNoEnable", enSeen, 1'b0);
        checkOutput("zeroDone", zDone, 1'b1);
        checkOutput("zeroCount", zCount, 0);
    endtask

    // Asynchronous reset while memory beat 5 is presented, then a new run.
    task automatic resetMidDump();
        int expCycles;
        bit found;
        found = 0;
        applyStimulus(0, 0, expCycles);
        for (int i = 0; i < 400; i++) begin
            if (expQ.size() == MW - 5 && dump_valid && dump_kind) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("reachedMemBeat5", found, 1'b1);
        checkOutput("memBeat5Index", dump_index, 20);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetCtrl", {cpu_en, dump_valid, busy, done, dump_kind}, 5'b0);
        checkOutput("asyncResetCount", cycle_count, 0);
        checkOutput("asyncResetAddr", {dbg_reg_a, dbg_mem_a, dump_index}, 66'b0);
        expQ.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idleAfterReset", {busy, done}, 2'b00);
        applyStimulus(0, 1, expCycles);
        finishRun(expCycles, 1);
    endtask

    initial begin
        int expCycles;
        #1;
        checkOutput("resetCtrl", {cpu_en, dump_valid, busy, done, dump_kind}, 5'b0);
        checkOutput("resetCount", cycle_count, 0);
        checkOutput("resetIndex", dump_index, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        zeroTest();

        resetDut();
        applyStimulus(3, 1, expCycles);
        finishRun(expCycles, 1);

        resetDut();
        applyStimulus(0, 1, expCycles);
        finishRun(expCycles, 1);

        resetDut();
        applyStimulus(0, 2, expCycles);
        finishRun(expCycles, 2);

        for (int r = 0; r < 5; r++) begin
            resetDut();
            applyStimulus($urandom_range(1, CYC + 3), 0, expCycles);
            finishRun(expCycles, 0);
        end

        resetDut();
        resetMidDump();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- CYCLES, 10000, max CPU clock-enabled cycles per run.
- NREGS, 32, register-file entries dumped.
- MEM_WORDS, 64, data-memory words dumped.
- DATA_W, 32, data width.
REQ-002 Clock and reset SHALL be one clock, reset asynchronous active-low:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
REQ-003 Run-control ports SHALL be:
- start  in  1  begin run, sampled in IDLE only.
- halt_req  in  1  early stop request from CPU side (e.g. pc == pc_new).
- cpu_en  out  1  enable for PC/register/data-memory write paths.
REQ-004 Debug read ports SHALL be:
- dbg_reg_a  out  $clog2(NREGS)  register-file read index.
- dbg_reg_rd  in  DATA_W  combinational register read data.
- dbg_mem_a  out  32  data-memory byte address, index*4.
- dbg_mem_rd  in  DATA_W  combinational memory read data.
REQ-005 Dump stream ports SHALL be:
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  consumer accepts beat.
- dump_kind  out  1  0=register, 1=memory.
- dump_index  out  32  register index or memory byte address.
- dump_data  out  DATA_W  dumped value.
REQ-006 Status ports SHALL be:
- busy  out  1  high in RUN/DUMP_REG/DUMP_MEM.
- done  out  1  high in DONE.
- cycle_count  out  32  enabled cycles completed in current run.

Function
REQ-007 FSM states SHALL be IDLE, RUN, DUMP_REG, DUMP_MEM, DONE.
REQ-008 IDLE->RUN SHALL occur on the edge where start=1; cycle_count cleared to 0 on that edge.
REQ-009 In RUN, cpu_en SHALL be 1 combinationally; cycle_count SHALL increment by 1 each edge.
REQ-010 RUN->DUMP_REG SHALL occur on the edge where cycle_count==CYCLES-1 or halt_req=1, whichever first; that edge still counts, so cycle_count equals cycles actually executed.
REQ-011 CYCLES=0 SHALL go IDLE->DUMP_REG directly, cpu_en never asserted, cycle_count=0.
REQ-012 cpu_en SHALL be 0 in every state other than RUN.
REQ-013 DUMP_REG SHALL emit NREGS beats, index 0..NREGS-1 ascending.
- dump_kind=0, dump_index=idx, dbg_reg_a=idx, dump_data=dbg_reg_rd.
REQ-014 DUMP_MEM SHALL emit MEM_WORDS beats, word w=0..MEM_WORDS-1 ascending.
- dump_kind=1, dbg_mem_a=dump_index=w*4, dump_data=dbg_mem_rd.
REQ-015 Handshake SHALL be valid/ready.
- dump_valid=1 throughout DUMP_REG/DUMP_MEM.
- A beat transfers on an edge with dump_valid&dump_ready.
- While dump_ready=0, kind/index/data SHALL hold stable.
- No beat is skipped or repeated.
REQ-016 Last register beat accepted SHALL move to DUMP_MEM with w=0; last memory beat accepted SHALL move to DONE.
REQ-017 Index counters SHALL NOT wrap; a counter equal to its last value on acceptance SHALL cause the state change and reset to 0.
REQ-018 DONE SHALL be terminal until rst_n; start ignored; dump_valid=0; cycle_count held.
REQ-019 start outside IDLE and halt_req outside RUN SHALL be ignored.
REQ-020 Back-to-back acceptance (dump_ready tied 1) SHALL yield one beat per cycle: NREGS+MEM_WORDS cycles total dump.

Reset
REQ-021 rst_n=0 SHALL immediately force the following regardless of state, including mid-run or mid-dump:
- state IDLE, cpu_en=0, dump_valid=0, busy=0, done=0.
- cycle_count=0, dbg_reg_a=0, dbg_mem_a=0, dump_index=0, dump_kind=0.
REQ-022 After rst_n deasserts, the first transition SHALL need start=1 on a rising edge.

Verification
REQ-023 Defaults, start pulse, dump_ready=1, halt_req=0 -> cpu_en high exactly 10000 cycles, cycle_count=10000, 96 beats (32 reg idx 0..31, 64 mem addr 0..252), done=1.
REQ-024 CYCLES=8, halt_req=1 on 3rd RUN cycle -> cpu_en high 3 cycles, cycle_count=3, dump starts next cycle.
REQ-025 NREGS=4, MEM_WORDS=2, dump_ready toggling 1,0,0,1... -> exactly 6 beats in order, fields stable while stalled, none duplicated.
REQ-026 CYCLES=0 -> cpu_en never 1, first beat is register 0 the cycle after start.
REQ-027 rst_n low during memory beat 5 -> all outputs at reset values asynchronously; new start reruns full sequence from cycle 0.
REQ-028 start held high through DONE -> stays DONE, no new run, cycle_count unchanged.
